aes_sched: RTL and testbench
============================

AES_SCHED -- requirements
Module: aes_sched

Interface
REQ-001 Parameter N, default 128, bit width of one AES block.
REQ-002 Parameter S, default NR_AES, fixed latency in cycles of the shared AES pipeline.
REQ-003 Parameter R, default 4, number of requesters; IDW = max(1, $clog2(R)).
REQ-004 Parameter D, default S+2, depth of the response buffer; D >= 2.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 en  in  1  level; permits leaving IDLE.
REQ-008 flush  in  1  pulse; requests a drain.
REQ-009 req_valid  in  R  per-requester request valid.
REQ-010 req_data  in  R*N  request blocks, requester i at bits [i*N +: N].
REQ-011 req_ready  out  R  per-requester accept; one-hot or zero.
REQ-012 pipe_in_valid  out  1  block issued to the AES pipeline this cycle.
REQ-013 pipe_in_data  out  N  issued block.
REQ-014 pipe_out_data  in  N  pipeline result; pipe_in_data of cycle c appears in cycle c+S.
REQ-015 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-016 rsp_data / rsp_id  out / out  N / IDW  result block and originating requester index.
REQ-017 busy / flush_done  out / out  1 / 1  state != IDLE; one-cycle drain-complete pulse.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN, and SHALL enter IDLE on reset.
REQ-019 Transitions SHALL be: IDLE->RUN when en=1; RUN->DRAIN when flush=1 or en=0; DRAIN->IDLE when credit==D, with flush_done=1 in that transition cycle only; flush in IDLE or DRAIN SHALL be ignored.
REQ-020 credit SHALL be a counter initialised to D: -1 on accept, +1 on rsp handshake, net 0 when both occur in the same cycle, and never outside 0..D.
REQ-021 Accept SHALL occur only when state=RUN and credit>0, and SHALL grant at most one requester per cycle.
REQ-022 Arbitration SHALL be round-robin: grant the lowest index >= ptr with req_valid=1, wrapping modulo R; on accept, ptr <= granted+1 mod R; ptr SHALL reset to 0.
REQ-023 req_ready SHALL be combinational from req_valid, ptr, state and credit.
REQ-024 In the cycle after an accept, pipe_in_valid SHALL be 1 and pipe_in_data SHALL equal the accepted block (registered); otherwise pipe_in_valid=0 and pipe_in_data=0.
REQ-025 A shadow shift register of S stages SHALL carry {valid,id} aligned with pipe_in; when its last stage is valid, pipe_out_data and id SHALL be written to the response buffer in that cycle.
REQ-026 The response buffer SHALL be an in-order FIFO of depth D; rsp_valid = not empty; rsp_data/rsp_id show the head entry; a pop occurs on rsp_valid & rsp_ready.
REQ-027 Minimum accept-to-rsp_valid latency SHALL be S+2 cycles; ordering SHALL equal accept order.
REQ-028 A write and a pop in the same cycle SHALL both take effect, including when the buffer is full; the credit scheme SHALL guarantee no overflow.
REQ-029 en=0 in RUN SHALL still complete all in-flight blocks before IDLE.

Reset
REQ-030 On rst: state=IDLE, credit=D, ptr=0, shadow valids=0, buffer empty; all outputs 0 except none.
REQ-031 rst asserted mid-operation SHALL discard in-flight and buffered results without emitting them.

Configuration
REQ-032 With AES_SCHED_STALL_CNT_EN defined, a 32-bit output stall_cnt SHALL count cycles in RUN with any req_valid=1 and credit=0, saturating at all-ones and cleared by rst.
REQ-033 Without AES_SCHED_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent.

Structure
REQ-034 Package aes_sched_pkg SHALL hold the state enum typedef and the NR_AES default constant.
REQ-035 The round-robin grant logic SHALL be sub-module sched_rr_arb (R-wide request, ptr in, one-hot grant out).

Verification (R=4, S=10, D=12)
REQ-036 Requester 2 alone, 1 block 0xA5.., rsp_ready=1 -> pipe_in_valid 1 cycle after accept; rsp_valid 12 cycles after accept, rsp_id=2.
REQ-037 All 4 requesters valid continuously -> grants 0,1,2,3,0,...; responses in the same id order.
REQ-038 rsp_ready=0, all requesters valid -> exactly 12 accepts, then req_ready=0; buffer holds 12; one pop -> exactly one further accept.
REQ-039 flush pulse with 5 blocks in flight -> no further accepts; flush_done after the last rsp pop; state=IDLE.
REQ-040 rst mid-stream with 6 blocks in flight -> rsp_valid=0 in the cycle after reset; no stale responses afterwards.
REQ-041 Macro defined, credit=0 for 7 cycles with requests pending -> stall_cnt=7.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and defaults for the AES block scheduler.
// Holds the FSM state encoding and the default pipeline latency.
package aes_sched_pkg;

    localparam int NR_AES = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/aes_sched_if.sv
// Request, AES-pipeline and response signals of the scheduler.
// The slave side is the scheduler; the master side is its environment.
interface aes_sched_if #(
    parameter int N   = 128,
    parameter int R   = 4,
    parameter int IDW = (R > 1) ? $clog2(R) : 1
);
    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_data;
    logic [R-1:0]   req_ready;
    logic           pipe_in_valid;
    logic [N-1:0]   pipe_in_data;
    logic [N-1:0]   pipe_out_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [N-1:0]   rsp_data;
    logic [IDW-1:0] rsp_id;

    modport master (
        output req_valid, req_data, pipe_out_data, rsp_ready,
        input  req_ready, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, pipe_out_data, rsp_ready,
        output req_ready, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/sched_rr_arb.sv
// Round-robin one-hot grant: lowest requesting index at or above ptr, wrapping.
// ptr must be below R.
module sched_rr_arb #(
    parameter int R   = 4,
    parameter int IDW = 2
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [R-1:0]   grant
);
    logic [R-1:0] rot;
    logic [R-1:0] first;

    // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        rot   = R'({req, req} >> ptr);
        first = rot & (~rot + R'(1));
        grant = R'(({first, first} << ptr) >> R);
    end

endmodule

// File: rtl/aes_sched.sv
// Schedules R requesters onto one shared fixed-latency AES pipeline with an in-order,
// credit-protected response buffer. Optional stall counter: AES_SCHED_STALL_CNT_EN.
module aes_sched
    import aes_sched_pkg::*;
#(
    parameter  int N   = 128,
    parameter  int S   = NR_AES,
    parameter  int R   = 4,
    parameter  int D   = S + 2,
    localparam int IDW = (R > 1) ? $clog2(R) : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    output logic        busy,
    output logic        flush_done,
`ifdef AES_SCHED_STALL_CNT_EN
    output logic [31:0] stall_cnt,
`endif
    aes_sched_if.slave  bus
);
    // state  | meaning
    // IDLE   | nothing accepted, waiting for en
    // RUN    | accepting requests while credit remains
    // DRAIN  | no accepts; waiting for every credit to come home

    localparam int CW = $clog2(D + 1);
    localparam int PW = $clog2(D);
    localparam logic [CW-1:0] CRED_MAX = CW'(D);

    state_t         state;
    logic [CW-1:0]  credit;
    logic [IDW-1:0] ptr;
    logic [R-1:0]   grant;
    logic [IDW-1:0] gnt_idx;
    logic [N-1:0]   acc_data;
    logic           can_acc;
    logic           accept;
    logic           pop;
    logic           wr;

    logic [IDW-1:0] in_id;
    logic [S-1:0]   sh_v;
    logic [IDW-1:0] sh_id [S];

    logic [N-1:0]   buf_data [D];
    logic [IDW-1:0] buf_id   [D];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    sched_rr_arb #(.R(R), .IDW(IDW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        gnt_idx  = '0;
        acc_data = '0;
        for (int i = 0; i < R; i++) begin
            if (grant[i]) begin
                gnt_idx  = IDW'(i);
                acc_data = bus.req_data[i*N +: N];
            end
        end
    end

    assign can_acc       = (state == ST_RUN) && (credit != '0);
    assign accept        = can_acc && (|grant);
    assign bus.req_ready = can_acc ? grant : '0;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign wr            = sh_v[S-1];
    assign bus.rsp_valid = (count != '0);
    assign bus.rsp_data  = bus.rsp_valid ? buf_data[rptr] : '0;
    assign bus.rsp_id    = bus.rsp_valid ? buf_id[rptr] : '0;
    assign busy          = (state != ST_IDLE);
    assign flush_done    = (state == ST_DRAIN) && (credit == CRED_MAX);

    // Credit counts free slots across the pipeline and the response buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            credit <= CRED_MAX;
            ptr    <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (en) state <= ST_RUN;
                ST_RUN:   if (flush || !en) state <= ST_DRAIN;
                ST_DRAIN: if (credit == CRED_MAX) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if (accept && !pop)
                credit <= credit - CW'(1);
            else if (pop && !accept)
                credit <= credit + CW'(1);
            if (accept)
                ptr <= (gnt_idx == IDW'(R - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pipe_in_valid <= 1'b0;
            bus.pipe_in_data  <= '0;
            in_id             <= '0;
            sh_v              <= '0;
            wptr              <= '0;
            rptr              <= '0;
            count             <= '0;
        end else begin
            bus.pipe_in_valid <= accept;
            bus.pipe_in_data  <= accept ? acc_data : '0;
            in_id             <= gnt_idx;
            sh_v[0]           <= bus.pipe_in_valid;
            sh_id[0]          <= in_id;
            for (int k = 1; k < S; k++) begin
                sh_v[k]  <= sh_v[k-1];
                sh_id[k] <= sh_id[k-1];
            end
            if (wr) begin
                buf_data[wptr] <= bus.pipe_out_data;
                buf_id[wptr]   <= sh_id[S-1];
                wptr           <= ptr_inc(wptr);
            end
            if (pop)
                rptr <= ptr_inc(rptr);
            if (wr && !pop)
                count <= count + CW'(1);
            else if (pop && !wr)
                count <= count - CW'(1);
        end
    end

`ifdef AES_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if ((state == ST_RUN) && (|bus.req_valid) && (credit == '0) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_aes_sched.sv
// Randomised self-checking bench for aes_sched (R=4, S=10, D=12) against a
// queue-based reference model; optional stall-counter scenario under AES_SCHED_STALL_CNT_EN.
module tb_aes_sched;
    localparam int N   = 128;
    localparam int S   = 10;
    localparam int R   = 4;
    localparam int D   = 12;
    localparam int IDW = 2;
    localparam logic [N-1:0] MASK = {4{32'h3C5A_9E71}};
    localparam logic [N-1:0] BLK_A5 = {16{8'hA5}};

    typedef struct {
        logic [N-1:0] data;
        int           id;
        int           t_rdy;
    } rsp_t;

    logic clk = 1'b0;
    logic rst, en, flush, busy, flush_done;
`ifdef AES_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    aes_sched_if #(.N(N), .R(R)) bus ();

    aes_sched #(.N(N), .S(S), .R(R), .D(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .busy       (busy),
        .flush_done (flush_done),
`ifdef AES_SCHED_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Stand-in AES pipeline: a fixed transform delayed by S cycles.
    function automatic logic [N-1:0] aes_f(input logic [N-1:0] x);
        return {x[N-9:0], x[N-1:N-8]} ^ MASK;
    endfunction

    logic [N-1:0] dl [S];
    always @(posedge clk) begin
        dl[0] <= bus.pipe_in_data;
        for (int k = 1; k < S; k++) dl[k] <= dl[k-1];
    end
    assign bus.pipe_out_data = aes_f(dl[S-1]);

    // Reference model: state 0 idle, 1 run, 2 drain.
    rsp_t         exp_q [$];
    int           m_state, m_credit, m_ptr, m_stall, cyc, now, acc_id;
    logic         m_last_acc;
    logic [N-1:0] m_last_data;

    logic [R-1:0] obs_g, exp_g;
    logic         obs_rv, exp_rv, obs_busy, exp_busy, obs_fd, exp_fd, obs_piv, exp_piv, pop;
    logic [N-1:0] obs_pid, exp_pid, obs_d;
    int           obs_id;
    rsp_t         hd;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [R*N-1:0] rand_blocks();
        logic [R*N-1:0] v;
        for (int i = 0; i < R*N/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_credit = D; m_ptr = 0; m_stall = 0;
        m_last_acc = 1'b0; m_last_data = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; flush = 1'b0;
        bus.req_valid = '0; bus.rsp_ready = 1'b0; bus.req_data = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, sample outputs, advance the model.
    task automatic run_cycle(input logic [R-1:0] rv, input logic [R*N-1:0] rd,
                             input logic rr, input logic e, input logic fl);
        int i;
        rsp_t ent;
        @(negedge clk);
        bus.req_valid = rv; bus.req_data = rd; bus.rsp_ready = rr; en = e; flush = fl;
        #1;
        now = cyc;
        exp_g = '0; acc_id = -1;
        if (m_state == 1 && m_credit > 0)
            for (int k = 0; k < R; k++) begin
                i = (m_ptr + k) % R;
                if (acc_id < 0 && rv[i]) acc_id = i;
            end
        if (acc_id >= 0) exp_g[acc_id] = 1'b1;
        exp_rv   = (exp_q.size() > 0) && (exp_q[0].t_rdy <= cyc);
        exp_busy = (m_state != 0);
        exp_fd   = (m_state == 2) && (m_credit == D);
        exp_piv  = m_last_acc;
        exp_pid  = m_last_data;
        obs_g = bus.req_ready; obs_rv = bus.rsp_valid; obs_d = bus.rsp_data;
        obs_id = int'(bus.rsp_id); obs_busy = busy; obs_fd = flush_done;
        obs_piv = bus.pipe_in_valid; obs_pid = bus.pipe_in_data;
        pop = exp_rv && rr;
        if (pop) hd = exp_q.pop_front();
        if (m_state == 1 && (|rv) && m_credit == 0) m_stall++;
        m_last_acc  = (acc_id >= 0);
        m_last_data = (acc_id >= 0) ? rd[acc_id*N +: N] : '0;
        if (acc_id >= 0) begin
            ent.data = aes_f(rd[acc_id*N +: N]); ent.id = acc_id; ent.t_rdy = cyc + S + 2;
            exp_q.push_back(ent);
            m_ptr = (acc_id + 1) % R;
        end
        m_credit = m_credit - ((acc_id >= 0) ? 1 : 0) + (pop ? 1 : 0);
        case (m_state)
            0: if (e) m_state = 1;
            1: if (fl || !e) m_state = 2;
            2: if (exp_fd) m_state = 0;
            default: m_state = 0;
        endcase
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        bus.req_valid = '1; en = 1'b0;
        #1;
        n_chk++; if (bus.req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_chk++; if (bus.pipe_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_in_valid got=%b exp=0", bus.pipe_in_valid); end
        n_chk++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
        n_chk++; if (bus.rsp_data !== '0 || bus.pipe_in_data !== '0) begin n_fail++; $display("FAIL reset_data rsp=%h pipe=%h exp=0", bus.rsp_data, bus.pipe_in_data); end
    endtask

    task automatic test_single();
        int start, piv_c, rsp_c;
        start = -1; piv_c = -1; rsp_c = -1;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            run_cycle((start < 0) ? 4'b0100 : 4'b0000, {R{BLK_A5}}, 1'b1, 1'b1, 1'b0);
            n_chk++; if (obs_g !== exp_g) begin n_fail++; $display("FAIL single_grant cyc=%0d got=%b exp=%b", now, obs_g, exp_g); end
            if (acc_id >= 0 && start < 0) start = now;
            if (obs_piv && piv_c < 0) begin
                piv_c = now;
                n_chk++; if (obs_pid !== BLK_A5) begin n_fail++; $display("FAIL single_pipe_data got=%h exp=%h", obs_pid, BLK_A5); end
            end
            if (obs_rv && rsp_c < 0) begin
                rsp_c = now;
                n_chk++; if (obs_id !== 2 || obs_d !== aes_f(BLK_A5)) begin n_fail++; $display("FAIL single_rsp id=%0d data=%h exp id=2 data=%h", obs_id, obs_d, aes_f(BLK_A5)); end
            end
        end
        n_chk++; if (piv_c - start !== 1) begin n_fail++; $display("FAIL single_pipe_lat got=%0d exp=1", piv_c - start); end
        n_chk++; if (rsp_c - start !== 12) begin n_fail++; $display("FAIL single_rsp_lat got=%0d exp=12", rsp_c - start); end
    endtask

    task automatic test_round_robin();
        int gq [$];
        int rq [$];
        int bad;
        do_reset();
        for (int t = 0; t < 50; t++) begin
            run_cycle(4'b1111, rand_blocks(), 1'b1, 1'b1, 1'b0);
            n_chk++; if (obs_g !== exp_g) begin n_fail++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", now, obs_g, exp_g); end
            n_chk++; if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL rr_rsp_valid cyc=%0d got=%b exp=%b", now, obs_rv, exp_rv); end
            if (|obs_g) for (int i = 0; i < R; i++) if (obs_g[i]) gq.push_back(i);
            if (obs_rv) rq.push_back(obs_id);
            if (pop) begin
                n_chk++; if (obs_d !== hd.data || obs_id !== hd.id) begin n_fail++; $display("FAIL rr_rsp cyc=%0d id=%0d data=%h exp id=%0d data=%h", now, obs_id, obs_d, hd.id, hd.data); end
            end
        end
        bad = 0;
        foreach (gq[k]) if (gq[k] != k % R) bad++;
        n_chk++; if (bad != 0 || gq.size() < 30) begin n_fail++; $display("FAIL rr_grant_order errors=%0d grants=%0d exp errors=0", bad, gq.size()); end
        bad = 0;
        foreach (rq[k]) if (rq[k] != k % R) bad++;
        n_chk++; if (bad != 0 || rq.size() < 20) begin n_fail++; $display("FAIL rr_rsp_order errors=%0d rsps=%0d exp errors=0", bad, rq.size()); end
    endtask

    task automatic test_backpressure();
        int n_acc;
        n_acc = 0;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            run_cycle(4'b1111, rand_blocks(), 1'b0, 1'b1, 1'b0);
            n_chk++; if (obs_g !== exp_g) begin n_fail++; $display("FAIL bp_grant cyc=%0d got=%b exp=%b", now, obs_g, exp_g); end
            if (|obs_g) n_acc++;
        end
        n_chk++; if (n_acc !== 12) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=12", n_acc); end
        n_chk++; if (obs_g !== 4'b0 || obs_rv !== 1'b1) begin n_fail++; $display("FAIL bp_full ready=%b rsp_valid=%b exp 0000/1", obs_g, obs_rv); end
        run_cycle(4'b1111, rand_blocks(), 1'b1, 1'b1, 1'b0);
        n_chk++; if (obs_d !== hd.data || obs_id !== hd.id) begin n_fail++; $display("FAIL bp_pop id=%0d data=%h exp id=%0d data=%h", obs_id, obs_d, hd.id, hd.data); end
        n_acc = 0;
        for (int t = 0; t < 15; t++) begin
            run_cycle(4'b1111, rand_blocks(), 1'b0, 1'b1, 1'b0);
            if (|obs_g) n_acc++;
        end
        n_chk++; if (n_acc !== 1) begin n_fail++; $display("FAIL bp_after_pop accepts got=%0d exp=1", n_acc); end
    endtask

    task automatic test_flush();
        int n_acc, acc_after, pops, fd_seen, pops_at_fd;
        n_acc = 0; acc_after = 0; pops = 0; fd_seen = 0; pops_at_fd = -1;
        do_reset();
        for (int t = 0; t < 30 && n_acc < 5; t++) begin
            run_cycle(4'b1111, rand_blocks(), 1'b1, 1'b1, 1'b0);
            if (|obs_g) n_acc++;
        end
        run_cycle(4'b0000, rand_blocks(), 1'b1, 1'b1, 1'b1);
        for (int t = 0; t < 80 && fd_seen == 0; t++) begin
            run_cycle(4'($urandom), rand_blocks(), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
            n_chk++; if (obs_fd !== exp_fd) begin n_fail++; $display("FAIL flush_done cyc=%0d got=%b exp=%b", now, obs_fd, exp_fd); end
            if (|obs_g) acc_after++;
            if (obs_fd) begin fd_seen = 1; pops_at_fd = pops; end
            if (obs_rv && bus.rsp_ready) begin
                pops++;
                n_chk++; if (!pop || obs_d !== hd.data || obs_id !== hd.id) begin n_fail++; $display("FAIL flush_rsp cyc=%0d id=%0d data=%h exp id=%0d data=%h", now, obs_id, obs_d, hd.id, hd.data); end
            end
        end
        n_chk++; if (fd_seen !== 1) begin n_fail++; $display("FAIL flush_timeout seen=%0d exp=1", fd_seen); end
        n_chk++; if (acc_after !== 0) begin n_fail++; $display("FAIL flush_accepts got=%0d exp=0", acc_after); end
        n_chk++; if (pops_at_fd !== 5) begin n_fail++; $display("FAIL flush_pops got=%0d exp=5", pops_at_fd); end
        run_cycle(4'b1111, rand_blocks(), 1'b1, 1'b0, 1'b0);
        n_chk++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle busy got=%b exp=0", obs_busy); end
    endtask

    task automatic test_reset_mid();
        int n_acc, stale;
        n_acc = 0; stale = 0;
        do_reset();
        for (int t = 0; t < 30 && n_acc < 6; t++) begin
            run_cycle(4'b1111, rand_blocks(), 1'b0, 1'b1, 1'b0);
            if (|obs_g) n_acc++;
        end
        do_reset();
        #1;
        n_chk++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state rsp_valid=%b busy=%b exp 0/0", bus.rsp_valid, busy); end
        for (int t = 0; t < 30; t++) begin
            run_cycle(4'b0000, rand_blocks(), 1'b1, 1'b1, 1'b0);
            if (obs_rv) stale++;
        end
        n_chk++; if (stale !== 0) begin n_fail++; $display("FAIL midrst_stale got=%0d exp=0", stale); end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 800; t++) begin
            run_cycle(4'($urandom), rand_blocks(), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 59) == 0));
            n_chk++; if (obs_g !== exp_g) begin n_fail++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", now, obs_g, exp_g); end
            n_chk++; if (obs_rv !== exp_rv) begin n_fail++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", now, obs_rv, exp_rv); end
            n_chk++; if (obs_busy !== exp_busy || obs_fd !== exp_fd) begin n_fail++; $display("FAIL rnd_status cyc=%0d busy=%b fd=%b exp %b/%b", now, obs_busy, obs_fd, exp_busy, exp_fd); end
            n_chk++; if (obs_piv !== exp_piv || obs_pid !== exp_pid) begin n_fail++; $display("FAIL rnd_pipe_in cyc=%0d v=%b d=%h exp %b/%h", now, obs_piv, obs_pid, exp_piv, exp_pid); end
            if (pop) begin
                n_chk++; if (obs_d !== hd.data || obs_id !== hd.id) begin n_fail++; $display("FAIL rnd_rsp cyc=%0d id=%0d data=%h exp id=%0d data=%h", now, obs_id, obs_d, hd.id, hd.data); end
            end
        end
    endtask

`ifdef AES_SCHED_STALL_CNT_EN
    task automatic test_stall();
        do_reset();
        for (int t = 0; t < 60 && m_stall < 7; t++)
            run_cycle(4'b1111, rand_blocks(), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        n_chk++; if (stall_cnt !== 32'd7) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=7", stall_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0;
        bus.req_valid = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;
        cyc = 0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef AES_SCHED_STALL_CNT_EN
        test_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
